// File: rtl/riscv_dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM states, tag width
// and the layout of one response-pipeline entry.
package riscv_dmem_responder_pkg;

  localparam int TAG_W = 11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MAINT = 1'b1
  } state_t;

  typedef struct packed {
    logic             vld;
    logic             err;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } resp_t;

endpackage

// File: rtl/riscv_dmem_ram.sv
// Single-port word array with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module riscv_dmem_ram #(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: fixed-latency read/write responses through a shift
// register, plus a busy window for flush/invalidate that blocks new requests.
module riscv_dmem_responder
  import riscv_dmem_responder_pkg::*;
#(
  parameter int MEM_WORDS    = 4096,
  parameter int LATENCY      = 2,
  parameter int MAINT_CYCLES = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_data_wr_i,
  input  logic             mem_rd_i,
  input  logic [3:0]       mem_wr_i,
  input  logic             mem_cacheable_i,
  input  logic [TAG_W-1:0] mem_req_tag_i,
  input  logic             mem_invalidate_i,
  input  logic             mem_flush_i,
  output logic             mem_accept_o,
  output logic             mem_ack_o,
  output logic             mem_error_o,
  output logic [31:0]      mem_data_rd_o,
  output logic [TAG_W-1:0] mem_resp_tag_o
);

  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CW = $clog2(MAINT_CYCLES + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [TAG_W-1:0] maint_tag_q, maint_tag_d;
  logic             maint_done;

  logic        is_wr, is_maint_req, req, accept, err, maint_start, rw_resp;
  logic [31:0] word_idx;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  resp_t       new_resp;
  resp_t       pipe_q [LATENCY];
  resp_t       tail;
  logic        unused_bits;

  assign unused_bits = ^{mem_cacheable_i, mem_addr_i[1:0]};

  assign is_wr        = |mem_wr_i;
  assign is_maint_req = mem_flush_i | mem_invalidate_i;
  assign req          = mem_rd_i | is_wr | is_maint_req;
  assign mem_accept_o = (state_q == ST_IDLE) && !rst_i;
  assign accept       = req && mem_accept_o;

  assign word_idx = {2'b00, mem_addr_i[31:2]};
  assign err      = (word_idx >= 32'(MEM_WORDS))
                  | (mem_rd_i & is_wr)
                  | (is_maint_req & (mem_rd_i | is_wr));

  assign maint_start = accept && is_maint_req && !err;
  assign rw_resp     = accept && !maint_start;
  assign ram_be      = (accept && !err) ? mem_wr_i : 4'b0000;

  riscv_dmem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk_i (clk_i),
    .addr  (mem_addr_i[AW+1:2]),
    .be    (ram_be),
    .wdata (mem_data_wr_i),
    .rdata (ram_rdata)
  );

  // Idle slots carry an all-zero entry so the tail can drive outputs directly.
  always_comb begin
    new_resp = '0;
    if (rw_resp) begin
      new_resp.vld  = 1'b1;
      new_resp.err  = err;
      new_resp.tag  = mem_req_tag_i;
      new_resp.data = (mem_rd_i && !err) ? ram_rdata : 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= new_resp;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tail = pipe_q[LATENCY-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      maint_tag_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      maint_tag_q <= maint_tag_d;
    end
  end

  // The ack fires in the cycle whose closing edge takes the counter to zero,
  // so accept stays low for exactly MAINT_CYCLES cycles after the request.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    maint_tag_d = maint_tag_q;
    maint_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (maint_start) begin
          state_d     = ST_MAINT;
          cnt_d       = CW'(MAINT_CYCLES);
          maint_tag_d = mem_req_tag_i;
        end
      end
      ST_MAINT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          maint_done = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_ack_o      = !rst_i && (tail.vld || maint_done);
  assign mem_error_o    = !rst_i && tail.err;
  assign mem_data_rd_o  = rst_i ? 32'h0 : tail.data;
  assign mem_resp_tag_o = rst_i      ? '0 :
                          tail.vld   ? tail.tag :
                          maint_done ? maint_tag_q : '0;

endmodule
